// File: rtl/cache_control_lw.sv
// cache_control_lw: sequences one CPU request against the tag-compare results.
// It drives the cache-array write enables, the datapath muxes and a strobed
// memory interface, with multi-word line fill, wait states and a selectable
// write policy.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | waiting for Strobe; all outputs low
// LOOKUP     | tag compare; hits finish here (write-through hits go on to MWR)
// EVICT_REQ  | memory write strobe for one dirty-line word (MSel=1)
// EVICT_WAIT | wait states of an eviction beat
// FILL_REQ   | memory read strobe for one line word
// FILL_WAIT  | wait states of a fill beat
// FILL_DATA  | write one returned word into the cache array
// MWR_REQ    | write-through memory strobe (MSel=0)
// MWR_WAIT   | write-through wait states; DReady on the final cycle
// DONE       | finish a missed request (read data valid / write merged)
module cache_control_lw #(
  parameter int WAIT_STATES = 4,
  parameter int LINE_WORDS  = 1,
  parameter int WRITE_BACK  = 0,
  localparam int IW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          Strobe,
  input  logic          DRW,
  input  logic          M,
  input  logic          V,
  input  logic          Dirty,
  output logic          DReady,
  output logic          W,
  output logic          WSel,
  output logic          RSel,
  output logic          MSel,
  output logic          MStrobe,
  output logic          MRW,
  output logic [IW-1:0] WordIdx,
  output logic          SetDirty,
  output logic          ClrDirty,
  output logic          Busy
);

  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [IW-1:0] LAST_BEAT = IW'(LINE_WORDS - 1);
  localparam logic [CW-1:0] C_WAIT = CW'(WAIT_STATES);
  // With zero wait states an eviction beat still gets one gap cycle, so that
  // back-to-back eviction strobes never land on consecutive cycles.
  localparam logic [CW-1:0] C_EVICT_WAIT = (WAIT_STATES > 0) ? CW'(WAIT_STATES) : CW'(1);
  localparam bit WB = (WRITE_BACK != 0);

  typedef enum logic [3:0] {
    IDLE, LOOKUP, EVICT_REQ, EVICT_WAIT, FILL_REQ,
    FILL_WAIT, FILL_DATA, MWR_REQ, MWR_WAIT, DONE
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_beat, w_beat_nxt;
  logic [CW-1:0]   r_wait, w_wait_nxt;
  logic            r_drw, w_drw_nxt;
  logic            w_hit, w_evict, w_wait_last, w_beat_last;

  assign w_hit       = M & V;
  assign w_evict     = WB & V & Dirty;
  assign w_wait_last = (r_wait <= CW'(1));
  assign w_beat_last = (r_beat == LAST_BEAT);

  // State, beat counter, wait counter and latched request type.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_wait  <= '0;
      r_drw   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      r_wait  <= w_wait_nxt;
      r_drw   <= w_drw_nxt;
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_wait_nxt  = r_wait;
    w_drw_nxt   = r_drw;
    case (r_state)
      IDLE: begin
        if (Strobe) begin
          w_state_nxt = LOOKUP;
          w_drw_nxt   = DRW;
        end
      end
      LOOKUP: begin
        if (r_drw && !WB) begin
          w_state_nxt = MWR_REQ;
        end else if (w_hit) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = w_evict ? EVICT_REQ : FILL_REQ;
        end
      end
      EVICT_REQ: begin
        w_wait_nxt  = C_EVICT_WAIT;
        w_state_nxt = EVICT_WAIT;
      end
      EVICT_WAIT: begin
        if (w_wait_last) begin
          w_wait_nxt = '0;
          if (w_beat_last) begin
            w_beat_nxt  = '0;
            w_state_nxt = FILL_REQ;
          end else begin
            w_beat_nxt  = r_beat + IW'(1);
            w_state_nxt = EVICT_REQ;
          end
        end else begin
          w_wait_nxt = r_wait - CW'(1);
        end
      end
      FILL_REQ: begin
        w_wait_nxt  = C_WAIT;
        w_state_nxt = (WAIT_STATES == 0) ? FILL_DATA : FILL_WAIT;
      end
      FILL_WAIT: begin
        if (w_wait_last) begin
          w_wait_nxt  = '0;
          w_state_nxt = FILL_DATA;
        end else begin
          w_wait_nxt = r_wait - CW'(1);
        end
      end
      FILL_DATA: begin
        if (w_beat_last) begin
          w_beat_nxt  = '0;
          w_state_nxt = DONE;
        end else begin
          w_beat_nxt  = r_beat + IW'(1);
          w_state_nxt = FILL_REQ;
        end
      end
      MWR_REQ: begin
        w_wait_nxt  = C_WAIT;
        w_state_nxt = (WAIT_STATES == 0) ? IDLE : MWR_WAIT;
      end
      MWR_WAIT: begin
        if (w_wait_last) begin
          w_wait_nxt  = '0;
          w_state_nxt = IDLE;
        end else begin
          w_wait_nxt = r_wait - CW'(1);
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output decode; IDLE (and therefore reset) drives everything low.
  always_comb begin
    DReady   = 1'b0;
    W        = 1'b0;
    WSel     = 1'b0;
    RSel     = 1'b0;
    MSel     = 1'b0;
    MStrobe  = 1'b0;
    MRW      = 1'b0;
    WordIdx  = '0;
    SetDirty = 1'b0;
    ClrDirty = 1'b0;
    Busy     = (r_state != IDLE);
    case (r_state)
      LOOKUP: begin
        if (!r_drw) begin
          DReady = w_hit;
        end else if (!WB) begin
          W = w_hit;
        end else if (w_hit) begin
          W        = 1'b1;
          SetDirty = 1'b1;
          DReady   = 1'b1;
        end
      end
      EVICT_REQ: begin
        MStrobe = 1'b1;
        MRW     = 1'b1;
        MSel    = 1'b1;
        WordIdx = r_beat;
      end
      EVICT_WAIT: begin
        MRW     = 1'b1;
        MSel    = 1'b1;
        WordIdx = r_beat;
      end
      FILL_REQ: begin
        MStrobe = 1'b1;
        WordIdx = r_beat;
      end
      FILL_WAIT: WordIdx = r_beat;
      FILL_DATA: begin
        W        = 1'b1;
        WSel     = 1'b1;
        WordIdx  = r_beat;
        ClrDirty = w_beat_last;
      end
      MWR_REQ: begin
        MStrobe = 1'b1;
        MRW     = 1'b1;
        DReady  = (WAIT_STATES == 0);
      end
      MWR_WAIT: begin
        MRW    = 1'b1;
        DReady = w_wait_last;
      end
      DONE: begin
        DReady = 1'b1;
        if (r_drw) begin
          W        = 1'b1;
          SetDirty = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_control_lw.sv
// Directed bench for cache_control_lw: three configurations, one cycle-exact
// vector table plus hand-written reset sequences.
module tb_cache_control_lw;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] strb, drw, mm, vv, dty;
  logic [2:0] dready, wen, wsel, rsel, msel, mstb, mrw, setd, clrd, busy;
  logic       a_idx;
  logic [1:0] b_idx;
  logic       c_idx;
  logic [13:0] out_v [3];

  // A: defaults (4 wait states, 1-word line, write-through)
  cache_control_lw #(.WAIT_STATES(4), .LINE_WORDS(1), .WRITE_BACK(0)) u_a (
    .clk(clk), .reset(rst_n), .Strobe(strb[0]), .DRW(drw[0]), .M(mm[0]), .V(vv[0]),
    .Dirty(dty[0]), .DReady(dready[0]), .W(wen[0]), .WSel(wsel[0]), .RSel(rsel[0]),
    .MSel(msel[0]), .MStrobe(mstb[0]), .MRW(mrw[0]), .WordIdx(a_idx),
    .SetDirty(setd[0]), .ClrDirty(clrd[0]), .Busy(busy[0]));

  // B: 2 wait states, 4-word line, write-back
  cache_control_lw #(.WAIT_STATES(2), .LINE_WORDS(4), .WRITE_BACK(1)) u_b (
    .clk(clk), .reset(rst_n), .Strobe(strb[1]), .DRW(drw[1]), .M(mm[1]), .V(vv[1]),
    .Dirty(dty[1]), .DReady(dready[1]), .W(wen[1]), .WSel(wsel[1]), .RSel(rsel[1]),
    .MSel(msel[1]), .MStrobe(mstb[1]), .MRW(mrw[1]), .WordIdx(b_idx),
    .SetDirty(setd[1]), .ClrDirty(clrd[1]), .Busy(busy[1]));

  // C: no wait states, 2-word line, write-through
  cache_control_lw #(.WAIT_STATES(0), .LINE_WORDS(2), .WRITE_BACK(0)) u_c (
    .clk(clk), .reset(rst_n), .Strobe(strb[2]), .DRW(drw[2]), .M(mm[2]), .V(vv[2]),
    .Dirty(dty[2]), .DReady(dready[2]), .W(wen[2]), .WSel(wsel[2]), .RSel(rsel[2]),
    .MSel(msel[2]), .MStrobe(mstb[2]), .MRW(mrw[2]), .WordIdx(c_idx),
    .SetDirty(setd[2]), .ClrDirty(clrd[2]), .Busy(busy[2]));

  assign out_v[0] = {dready[0], wen[0], wsel[0], rsel[0], msel[0], mstb[0], mrw[0],
                     setd[0], clrd[0], busy[0], 3'b000, a_idx};
  assign out_v[1] = {dready[1], wen[1], wsel[1], rsel[1], msel[1], mstb[1], mrw[1],
                     setd[1], clrd[1], busy[1], 2'b00, b_idx};
  assign out_v[2] = {dready[2], wen[2], wsel[2], rsel[2], msel[2], mstb[2], mrw[2],
                     setd[2], clrd[2], busy[2], 3'b000, c_idx};

  localparam logic [13:0] K_DR  = 14'h2000;
  localparam logic [13:0] K_WE  = 14'h1000;
  localparam logic [13:0] K_WS  = 14'h0800;
  localparam logic [13:0] K_MS  = 14'h0200;
  localparam logic [13:0] K_MST = 14'h0100;
  localparam logic [13:0] K_MRW = 14'h0080;
  localparam logic [13:0] K_SD  = 14'h0040;
  localparam logic [13:0] K_CD  = 14'h0020;
  localparam logic [13:0] K_BSY = 14'h0010;

  typedef struct {
    int          inst;
    logic        s, d, m, v, dt;
    logic [13:0] exp;
    string       tag;
  } vec_t;

  vec_t vq[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic add(input int inst, input logic s, input logic d, input logic m,
                     input logic v, input logic dt, input logic [13:0] e, input string tag);
    vec_t r;
    r.inst = inst; r.s = s; r.d = d; r.m = m; r.v = v; r.dt = dt; r.exp = e; r.tag = tag;
    vq.push_back(r);
  endtask

  task automatic check(input int inst, input logic [13:0] e, input string tag);
    n_vec++;
    if (out_v[inst] !== e) begin
      n_bad++;
      $display("FAIL %s (inst %0d): got %h expected %h", tag, inst, out_v[inst], e);
    end
  endtask

  task automatic drive_idle();
    strb = '0; drw = '0; mm = '0; vv = '0; dty = '0;
  endtask

  initial begin
    drive_idle();

    // Instance A: read hit, 1 cycle to DReady
    add(0, 1, 0, 1, 1, 0, K_DR | K_BSY, "A_rd_hit");
    add(0, 0, 0, 1, 1, 0, 14'h0, "A_rd_hit_idle");
    // A: read miss, Dirty ignored in write-through; DReady in cycle 1+(2+4)+1 = 8
    add(0, 1, 0, 0, 1, 1, K_BSY, "A_rdmiss_lookup");
    add(0, 0, 0, 0, 1, 1, K_MST | K_BSY, "A_fill_req");
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1, 1, K_BSY, "A_fill_wait");
    add(0, 0, 0, 0, 1, 1, K_WE | K_WS | K_CD | K_BSY, "A_fill_data");
    add(0, 0, 0, 0, 1, 1, K_DR | K_BSY, "A_done");
    add(0, 0, 0, 0, 1, 1, 14'h0, "A_rdmiss_idle");
    // A: write hit, Strobe held high (must be ignored while busy)
    add(0, 1, 1, 1, 1, 0, K_WE | K_BSY, "A_wrhit_lookup");
    add(0, 1, 1, 1, 1, 0, K_MST | K_MRW | K_BSY, "A_mwr_req");
    for (int i = 0; i < 3; i++) add(0, 1, 1, 1, 1, 0, K_MRW | K_BSY, "A_mwr_wait");
    add(0, 1, 1, 1, 1, 0, K_MRW | K_DR | K_BSY, "A_mwr_last");
    add(0, 0, 1, 1, 1, 0, 14'h0, "A_wrhit_idle");
    // A: write miss, no cache write
    add(0, 1, 1, 0, 1, 0, K_BSY, "A_wrmiss_lookup");
    add(0, 0, 1, 0, 1, 0, K_MST | K_MRW | K_BSY, "A_wrmiss_req");
    for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 1, 0, K_MRW | K_BSY, "A_wrmiss_wait");
    add(0, 0, 1, 0, 1, 0, K_MRW | K_DR | K_BSY, "A_wrmiss_last");
    add(0, 0, 1, 0, 1, 0, 14'h0, "A_wrmiss_idle");

    // Instance B: read miss on a dirty line -> 4 evict beats, 4 fill beats
    add(1, 1, 0, 0, 1, 1, K_BSY, "B_rdmiss_lookup");
    for (int b = 0; b < 4; b++) begin
      add(1, 0, 0, 0, 1, 1, K_MST | K_MRW | K_MS | K_BSY | 14'(b), "B_evict_req");
      add(1, 0, 0, 0, 1, 1, K_MRW | K_MS | K_BSY | 14'(b), "B_evict_wait");
      add(1, 0, 0, 0, 1, 1, K_MRW | K_MS | K_BSY | 14'(b), "B_evict_wait");
    end
    for (int b = 0; b < 4; b++) begin
      add(1, 0, 0, 0, 1, 1, K_MST | K_BSY | 14'(b), "B_fill_req");
      add(1, 0, 0, 0, 1, 1, K_BSY | 14'(b), "B_fill_wait");
      add(1, 0, 0, 0, 1, 1, K_BSY | 14'(b), "B_fill_wait");
      add(1, 0, 0, 0, 1, 1, K_WE | K_WS | K_BSY | 14'(b) | ((b == 3) ? K_CD : 14'h0),
          "B_fill_data");
    end
    add(1, 0, 0, 0, 1, 1, K_DR | K_BSY, "B_rd_done");
    add(1, 0, 0, 0, 1, 1, 14'h0, "B_rdmiss_idle");
    // B: write hit with Strobe held; next request only after return to IDLE
    add(1, 1, 1, 1, 1, 0, K_WE | K_SD | K_DR | K_BSY, "B_wrhit");
    add(1, 1, 1, 1, 1, 0, 14'h0, "B_wrhit_return");
    add(1, 1, 0, 1, 1, 0, K_DR | K_BSY, "B_next_rdhit");
    add(1, 0, 0, 1, 1, 0, 14'h0, "B_next_idle");
    // B: write miss on a clean line -> fill only, then merge write in DONE
    add(1, 1, 1, 0, 1, 0, K_BSY, "B_wrmiss_lookup");
    for (int b = 0; b < 4; b++) begin
      add(1, 0, 1, 0, 1, 0, K_MST | K_BSY | 14'(b), "B_wfill_req");
      add(1, 0, 1, 0, 1, 0, K_BSY | 14'(b), "B_wfill_wait");
      add(1, 0, 1, 0, 1, 0, K_BSY | 14'(b), "B_wfill_wait");
      add(1, 0, 1, 0, 1, 0, K_WE | K_WS | K_BSY | 14'(b) | ((b == 3) ? K_CD : 14'h0),
          "B_wfill_data");
    end
    add(1, 0, 1, 0, 1, 0, K_WE | K_SD | K_DR | K_BSY, "B_wr_done");
    add(1, 0, 1, 0, 1, 0, 14'h0, "B_wrmiss_idle");

    // Instance C: zero wait states, 2-word fill; DReady in cycle 1+2*2+1 = 6
    add(2, 1, 0, 1, 0, 0, K_BSY, "C_rdmiss_lookup");
    add(2, 0, 0, 1, 0, 0, K_MST | K_BSY, "C_fill_req0");
    add(2, 0, 0, 1, 0, 0, K_WE | K_WS | K_BSY, "C_fill_data0");
    add(2, 0, 0, 1, 0, 0, K_MST | K_BSY | 14'd1, "C_fill_req1");
    add(2, 0, 0, 1, 0, 0, K_WE | K_WS | K_CD | K_BSY | 14'd1, "C_fill_data1");
    add(2, 0, 0, 1, 0, 0, K_DR | K_BSY, "C_done");
    add(2, 0, 0, 1, 0, 0, 14'h0, "C_rdmiss_idle");
    add(2, 1, 1, 1, 1, 0, K_WE | K_BSY, "C_wrhit_lookup");
    add(2, 0, 1, 1, 1, 0, K_MST | K_MRW | K_DR | K_BSY, "C_mwr_req");
    add(2, 0, 1, 1, 1, 0, 14'h0, "C_wrhit_idle");

    // Reset held 3 cycles: everything low
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) check(i, 14'h0, "reset_state");
    rst_n = 1'b1;

    foreach (vq[k]) begin
      drive_idle();
      strb[vq[k].inst] = vq[k].s;
      drw[vq[k].inst]  = vq[k].d;
      mm[vq[k].inst]   = vq[k].m;
      vv[vq[k].inst]   = vq[k].v;
      dty[vq[k].inst]  = vq[k].dt;
      @(posedge clk);
      @(negedge clk);
      check(vq[k].inst, vq[k].exp, vq[k].tag);
    end

    // Reset asserted during a fill wait on instance A
    drive_idle();
    strb[0] = 1'b1; vv[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    strb[0] = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check(0, K_BSY, "A_pre_reset_wait");
    #2 rst_n = 1'b0;
    #1 check(0, 14'h0, "A_async_reset");
    @(negedge clk);
    check(0, 14'h0, "A_reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    check(0, 14'h0, "A_post_reset_idle");
    strb[0] = 1'b1; mm[0] = 1'b1; vv[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    check(0, K_DR | K_BSY, "A_post_reset_hit");
    strb[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    check(0, 14'h0, "A_post_reset_done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
